codec_cfg_arbiter: RTL



---
 rtl/codec_cfg_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/codec_cfg_arbiter.sv
// Round-robin arbiter sharing the codec I2C write engine between runtime requesters,
// with NACK retry, timeout and a shadow copy of the codec registers.
// Optional: define CODEC_CFG_SKIP_REDUNDANT_EN to skip writes that match the shadow.
module codec_cfg_arbiter #(
  parameter int         NUM_REQ     = 3,
  parameter logic [7:0] DEV_ADDR    = 8'h34,
  parameter int         MAX_RETRY   = 2,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic                 clk_n,
  input  logic                 rst,
  input  logic                 init_done,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [9*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   req_done,
  output logic [NUM_REQ-1:0]   req_err,
  output logic                 eng_start,
  output logic [23:0]          eng_frame,
  input  logic                 eng_done,
  input  logic                 eng_nack,
  input  logic [3:0]           shadow_sel,
  output logic [8:0]           shadow_val,
  output logic                 busy
);

  localparam int IW = 2;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);

`ifdef CODEC_CFG_SKIP_REDUNDANT_EN
  localparam bit SKIP_REDUNDANT = 1'b1;
`else
  localparam bit SKIP_REDUNDANT = 1'b0;
`endif

  // WM8731 power-on register values, R0..R9
  localparam logic [8:0] SHADOW_DEF [10] = '{
    9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
    9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
  };

  typedef enum logic [2:0] {IDLE, GRANT, CHECK, ISSUE, WAIT, RETIRE} state_t;

  state_t             state;
  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] lat_onehot;
  logic [6:0]         lat_addr;
  logic [8:0]         lat_data;
  logic [RW-1:0]      retry;
  logic [TW-1:0]      tcnt;
  logic               err_flag;
  logic [8:0]         shadow [10];

  logic [3:0]         valid_pad;
  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      cand;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [6:0]         pick_addr;
  logic [8:0]         pick_data;
  logic               addr_legal;
  logic               shadow_hit;

  assign valid_pad = 4'(req_valid);

  // Rotating-priority search: scanning backwards lets the candidate closest to ptr win.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (valid_pad[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
    pick_addr   = req_addr[7*int'(pick_idx) +: 7];
    pick_data   = req_data[9*int'(pick_idx) +: 9];
  end

  assign addr_legal = (lat_addr <= 7'd9) || (lat_addr == 7'd15);
  assign shadow_hit = (lat_addr <= 7'd9) && (shadow[lat_addr[3:0]] == lat_data);

  always_comb begin
    shadow_val = 9'd0;
    if (shadow_sel <= 4'd9) shadow_val = shadow[shadow_sel];
  end

  always_ff @(negedge clk_n or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      lat_onehot <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      retry      <= '0;
      tcnt       <= '0;
      err_flag   <= 1'b0;
      req_ready  <= '0;
      req_done   <= '0;
      req_err    <= '0;
      eng_start  <= 1'b0;
      eng_frame  <= '0;
      busy       <= 1'b0;
      for (int i = 0; i < 10; i++) shadow[i] <= SHADOW_DEF[i];
    end else begin
      req_ready <= '0;
      req_done  <= '0;
      req_err   <= '0;
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (init_done && (|req_valid)) begin
            state <= GRANT;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          // A requester may withdraw between IDLE and GRANT; then nothing is served.
          if (pick_found) begin
            req_ready  <= pick_onehot;
            lat_onehot <= pick_onehot;
            lat_addr   <= pick_addr;
            lat_data   <= pick_data;
            ptr        <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            err_flag   <= 1'b0;
            state      <= CHECK;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CHECK: begin
          if (!addr_legal) begin
            err_flag <= 1'b1;
            state    <= RETIRE;
          end else if (SKIP_REDUNDANT && shadow_hit) begin
            state <= RETIRE;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          eng_frame <= {DEV_ADDR, lat_addr, lat_data};
          eng_start <= 1'b1;
          tcnt      <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // The timeout fires as the counter steps onto TIMEOUT_CYC-1, so the error
          // pulse lands exactly TIMEOUT_CYC cycles after eng_start.
          if (eng_done) begin
            if (!eng_nack) begin
              state <= RETIRE;
            end else if (retry < RW'(MAX_RETRY)) begin
              retry <= retry + 1'b1;
              state <= ISSUE;
            end else begin
              err_flag <= 1'b1;
              state    <= RETIRE;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TW'(TIMEOUT_CYC - 2)) begin
              err_flag <= 1'b1;
              state    <= RETIRE;
            end
          end
        end
        RETIRE: begin
          req_done <= lat_onehot;
          req_err  <= err_flag ? lat_onehot : '0;
          retry    <= '0;
          if (!err_flag) begin
            if (lat_addr == 7'd15) begin
              for (int i = 0; i < 10; i++) shadow[i] <= SHADOW_DEF[i];
            end else if (lat_addr <= 7'd9) begin
              shadow[lat_addr[3:0]] <= lat_data;
            end
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
